// File: rtl/video_scanout_if.sv
// Pixel-write bus from the TIA into the scanout frame buffer.
`timescale 1ns/1ps
interface video_scanout_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int COLOR_WIDTH = 7
);
  logic                   vid_wr;
  logic [ADDR_WIDTH-1:0]  vid_addr;
  logic [COLOR_WIDTH-1:0] vid_dat;

  modport master (
    output vid_wr,
    output vid_addr,
    output vid_dat
  );

  modport slave (
    input vid_wr,
    input vid_addr,
    input vid_dat
  );
endinterface

// File: rtl/video_scanout.sv
// Frame buffer plus 640x480@60 scan engine with 4x/2x pixel replication.
// Emits colour index, sync and DE aligned through a 2-stage pipeline.
`timescale 1ns/1ps
module video_scanout #(
  parameter int FB_WIDTH    = 160,
  parameter int FB_HEIGHT   = 240,
  parameter int ADDR_WIDTH  = 16,
  parameter int COLOR_WIDTH = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   pix_en_i,
  video_scanout_if.slave         wr,
  output logic [COLOR_WIDTH-1:0] pix_o,
  output logic                   de_o,
  output logic                   hsync_o,
  output logic                   vsync_o,
  output logic                   frame_start_o,
  output logic                   wr_drop_o
);

  localparam int FB_DEPTH = FB_WIDTH * FB_HEIGHT;
  localparam int IW       = $clog2(FB_DEPTH);

  localparam logic [9:0] H_ACT  = 10'(4 * FB_WIDTH);
  localparam logic [9:0] H_SS   = 10'(4 * FB_WIDTH + 16);
  localparam logic [9:0] H_SE   = 10'(4 * FB_WIDTH + 112);
  localparam logic [9:0] H_LAST = 10'(4 * FB_WIDTH + 159);
  localparam logic [9:0] V_ACT  = 10'(2 * FB_HEIGHT);
  localparam logic [9:0] V_SS   = 10'(2 * FB_HEIGHT + 10);
  localparam logic [9:0] V_SE   = 10'(2 * FB_HEIGHT + 12);
  localparam logic [9:0] V_LAST = 10'(2 * FB_HEIGHT + 44);

  logic [COLOR_WIDTH-1:0] mem [FB_DEPTH];
  logic [COLOR_WIDTH-1:0] rd_q;

  logic [9:0] hcnt_q, hcnt_d;
  logic [9:0] vcnt_q, vcnt_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic de1_q, de1_d, hs1_q, hs1_d;
  logic vs1_q, vs1_d, fs1_q, fs1_d;

  logic [COLOR_WIDTH-1:0] pix_q, pix_d;
  logic de_q, de_d, hs_q, hs_d;
  logic vs_q, vs_d, fs_q, fs_d;
  logic drop_q, drop_d;

  logic active, in_hs, in_vs;
  logic wr_ok, rd_en;

  always_comb begin
    active = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    in_hs  = (hcnt_q >= H_SS) && (hcnt_q < H_SE);
    in_vs  = (vcnt_q >= V_SS) && (vcnt_q < V_SE);
    rd_addr = base_q + ADDR_WIDTH'(hcnt_q[9:2]);
    rd_en  = pix_en_i && active;
    wr_ok  = wr.vid_wr && (32'(wr.vid_addr) < FB_DEPTH);
    drop_d = wr.vid_wr && !wr_ok;

    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    base_d = base_q;
    de1_d  = de1_q;
    hs1_d  = hs1_q;
    vs1_d  = vs1_q;
    fs1_d  = fs1_q;
    pix_d  = pix_q;
    de_d   = de_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    fs_d   = 1'b0;

    if (pix_en_i) begin
      // Line base steps once per source line, i.e. after odd output lines.
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        if (vcnt_q == V_LAST) begin
          vcnt_d = '0;
          base_d = '0;
        end else begin
          vcnt_d = vcnt_q + 10'd1;
          if (vcnt_q < V_ACT && vcnt_q[0])
            base_d = base_q + ADDR_WIDTH'(FB_WIDTH);
        end
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end

      de1_d = active;
      hs1_d = !in_hs;
      vs1_d = !in_vs;
      fs1_d = (hcnt_q == '0) && (vcnt_q == '0);

      pix_d = de1_q ? rd_q : '0;
      de_d  = de1_q;
      hs_d  = hs1_q;
      vs_d  = vs1_q;
      fs_d  = fs1_q;
    end
  end

  // Plain NBA read and write give read-before-write on a shared address.
  always_ff @(posedge clk_i) begin
    if (wr_ok)
      mem[wr.vid_addr[IW-1:0]] <= wr.vid_dat;
    if (rd_en)
      rd_q <= mem[rd_addr[IW-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
      base_q <= '0;
      de1_q  <= 1'b0;
      hs1_q  <= 1'b1;
      vs1_q  <= 1'b1;
      fs1_q  <= 1'b0;
      pix_q  <= '0;
      de_q   <= 1'b0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      fs_q   <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      base_q <= base_d;
      de1_q  <= de1_d;
      hs1_q  <= hs1_d;
      vs1_q  <= vs1_d;
      fs1_q  <= fs1_d;
      pix_q  <= pix_d;
      de_q   <= de_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      fs_q   <= fs_d;
      drop_q <= drop_d;
    end
  end

  assign pix_o         = pix_q;
  assign de_o          = de_q;
  assign hsync_o       = hs_q;
  assign vsync_o       = vs_q;
  assign frame_start_o = fs_q;
  assign wr_drop_o     = drop_q;

endmodule

// File: tb/tb_video_scanout.sv
// Directed bench for video_scanout with a 160x4 buffer (53-line frame).
`timescale 1ns/1ps
module tb_video_scanout;

  localparam int FW = 160;
  localparam int FH = 4;
  localparam int HT = 800;
  localparam int VT = 2 * FH + 45;
  localparam int FT = HT * VT;
  localparam int VA = 2 * FH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pix_en = 1'b0;
  logic [6:0] pix;
  logic       de, hs, vs, fs, drop;

  int checks = 0;
  int errors = 0;

  video_scanout_if #(.ADDR_WIDTH(16), .COLOR_WIDTH(7)) wr_bus ();

  video_scanout #(
    .FB_WIDTH(FW),
    .FB_HEIGHT(FH),
    .ADDR_WIDTH(16),
    .COLOR_WIDTH(7)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .pix_en_i(pix_en),
    .wr(wr_bus),
    .pix_o(pix),
    .de_o(de),
    .hsync_o(hs),
    .vsync_o(vs),
    .frame_start_o(fs),
    .wr_drop_o(drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    wr_bus.vid_wr   = 1'b1;
    wr_bus.vid_addr = 16'(a);
    wr_bus.vid_dat  = 7'(d);
    tick;
    wr_bus.vid_wr   = 1'b0;
  endtask

  // Expected colour of a displayed pixel; -1 where the buffer is unknown.
  function automatic int exp_pix(input int h, input int v, input int fr);
    int a;
    if (h >= 4 * FW || v >= VA) return -1;
    a = (v / 2) * FW + h / 4;
    case (a)
      0:   return 'h55;
      159: return 'h2A;
      160: return 'h11;
      320: return 'h22;
      480: return 'h44;
      639: return 'h33;
      162: return (fr == 0 && h == 8 && v == 2) ? 'h0A : 'h7F;
      default: return -1;
    endcase
  endfunction

  initial begin
    int h, vl, fr, e;
    int bad, de_cnt, hs_lo, vs_lo, fs_cnt;
    int s0, s1, hf1, hr1, hf2, df1;
    logic ph, pd;

    wr_bus.vid_wr   = 1'b0;
    wr_bus.vid_addr = '0;
    wr_bus.vid_dat  = '0;

    repeat (3) tick;
    chk("rst_pix", 32'(pix), 0);
    chk("rst_de", 32'(de), 0);
    chk("rst_hs", 32'(hs), 1);
    chk("rst_vs", 32'(vs), 1);
    chk("rst_fs", 32'(fs), 0);
    chk("rst_drop", 32'(drop), 0);

    rst_n = 1'b1;
    wr(0, 'h55);
    wr(159, 'h2A);
    wr(160, 'h11);
    wr(320, 'h22);
    wr(480, 'h44);
    wr(162, 'h0A);
    wr(639, 'h33);
    chk("drop_valid", 32'(drop), 0);
    wr(640, 'h3C);
    chk("drop_640", 32'(drop), 1);
    tick;
    chk("drop_640_clr", 32'(drop), 0);
    wr('hFFFF, 'h3C);
    chk("drop_ffff", 32'(drop), 1);
    tick;
    chk("drop_ffff_clr", 32'(drop), 0);
    chk("hold_de", 32'(de), 0);
    chk("hold_fs", 32'(fs), 0);

    pix_en = 1'b1;
    tick;
    chk("lat1_fs", 32'(fs), 0);
    chk("lat1_de", 32'(de), 0);
    tick;
    chk("lat2_fs", 32'(fs), 1);

    bad = 0; de_cnt = 0; hs_lo = 0;
    vs_lo = 0; fs_cnt = 0;
    for (int k = 0; k <= FT + 1700; k++) begin
      if (k > 0) tick;
      h  = k % HT;
      vl = (k / HT) % VT;
      fr = k / FT;
      if (de !== (h < 640 && vl < VA)) bad++;
      if (hs !== !(h >= 656 && h < 752)) bad++;
      if (vs !== !(vl >= VA + 10 && vl < VA + 12)) bad++;
      if (!(h < 640 && vl < VA) && pix !== 7'd0) bad++;
      if (fr == 0) begin
        if (de) de_cnt++;
        if (!hs) hs_lo++;
        if (!vs) vs_lo++;
        if (k > 0 && fs) fs_cnt++;
      end
      if (k == FT) chk("fs_period", 32'(fs), 1);
      e = exp_pix(h, vl, fr);
      if (e >= 0)
        chk($sformatf("pix_f%0d_v%0d_h%0d", fr, vl, h),
            32'(pix), 32'(e));
      // Next edge reads (8,2) i.e. address 162 while it is written.
      if (k == 2 * HT + 8 - 2) begin
        wr_bus.vid_wr   = 1'b1;
        wr_bus.vid_addr = 16'd162;
        wr_bus.vid_dat  = 7'h7F;
      end else begin
        wr_bus.vid_wr = 1'b0;
      end
    end
    chk("timing_struct", 32'(bad), 0);
    chk("de_count", 32'(de_cnt), 640 * VA);
    chk("hs_low_count", 32'(hs_lo), 96 * VT);
    chk("vs_low_count", 32'(vs_lo), 2 * HT);
    chk("fs_extra", 32'(fs_cnt), 0);

    pix_en = 1'b0;
    rst_n  = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    s0 = -1; hf1 = -1; hr1 = -1;
    hf2 = -1; df1 = -1; fs_cnt = 0;
    vs_lo = 0; ph = 1'b1; pd = 1'b0;
    for (int j = 0; j <= 10004; j++) begin
      pix_en = (j % 4 == 0);
      tick;
      if (fs) begin
        fs_cnt++;
        if (s0 < 0) s0 = j;
      end
      if (ph && !hs) begin
        if (hf1 < 0) hf1 = j;
        else if (hf2 < 0) hf2 = j;
      end
      if (!ph && hs && hr1 < 0) hr1 = j;
      if (pd && !de && df1 < 0) df1 = j;
      if (!vs) vs_lo++;
      ph = hs;
      pd = de;
    end
    pix_en = 1'b0;
    chk("q_fs_pos", 32'(s0), 4);
    chk("q_fs_count", 32'(fs_cnt), 1);
    chk("q_de_len", 32'(df1 - s0), 2560);
    chk("q_hs_fall", 32'(hf1 - s0), 656 * 4);
    chk("q_hs_len", 32'(hr1 - hf1), 384);
    chk("q_line_len", 32'(hf2 - hf1), 3200);
    chk("q_vs_idle", 32'(vs_lo), 0);
    chk("pre_rst_de", 32'(de), 1);

    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_de", 32'(de), 0);
    chk("mid_rst_hs", 32'(hs), 1);
    chk("mid_rst_vs", 32'(vs), 1);
    chk("mid_rst_pix", 32'(pix), 0);
    tick;
    tick;
    rst_n = 1'b1;
    s1 = -1;
    for (int j = 0; j <= 7; j++) begin
      pix_en = (j % 4 == 0);
      tick;
      if (fs && s1 < 0) s1 = j;
      if (j == 3) chk("post_rst_de", 32'(de), 0);
      if (j == 4) chk("post_rst_de_on", 32'(de), 1);
    end
    chk("post_rst_fs_pos", 32'(s1), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
